// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store sequencer: MIPS memory opcodes,
// FSM state encoding, and byte-lane helpers.
// Little-endian lanes: byte offset 0 is bits [7:0], offset 3 is bits [31:24].
package mem_access_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Halfword accesses need an even address, word accesses a multiple of 4.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = off[0];
      OP_LW, OP_SW:         bad = |off;
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  // LB/LH sign-extend, LBU/LHU zero-extend, anything else passes the word.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [5:0]  op);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   v = {{24{b[7]}}, b};
      OP_LBU:  v = {24'd0, b};
      OP_LH:   v = {{16{h[15]}}, h};
      OP_LHU:  v = {16'd0, h};
      default: v = word;
    endcase
    return v;
  endfunction

  // Build the word written back for a store: SB/SH replace one lane of the
  // word just read, SW replaces the whole word.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [5:0]  op,
                                             input logic [31:0] data);
    logic [31:0] m;
    m = word;
    case (op)
      OP_SB: begin
        case (off)
          2'd0:    m[7:0]   = data[7:0];
          2'd1:    m[15:8]  = data[7:0];
          2'd2:    m[23:16] = data[7:0];
          default: m[31:24] = data[7:0];
        endcase
      end
      OP_SH: begin
        if (off[1]) m[31:16] = data[15:0];
        else        m[15:0]  = data[15:0];
      end
      default: m = data;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Purpose: combinational lane select + sign/zero extension of a memory word.
// Latency: 0 cycles (pure combinational). Backpressure: none, no handshake.
// Ports: rd_word (32b memory word), off (byte offset), opcode, load_val (result).
module load_extract
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  off,
  input  logic [5:0]  opcode,
  output logic [31:0] load_val
);

  always_comb begin
    load_val = extract_lane(rd_word, off, opcode);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: load/store sequencer driving a word-addressed data memory; sub-word
//   stores are read-modify-write. Latency accept->done: load 2, SW 2, SB/SH 3, error 1.
// Backpressure: one request at a time; ready only in IDLE, req ignored otherwise.
// Ports: CLK/RST (async, active-high); core side req/opcode/addr/wdata in,
//   ready/done/err/rdata out; memory side A/WD/WE out, RD in (async read).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       WD,
  output logic              WE,
  input  logic [31:0]       RD
);

  state_t            state;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       load_val;
  logic [31:0]       merge_word;
  logic              accept_bad;

  // RD is valid during LOAD/RMW_RD because A is already registered to the
  // word address on entry to those states.
  load_extract u_load_extract (
    .rd_word  (RD),
    .off      (addr_q[1:0]),
    .opcode   (op_q),
    .load_val (load_val)
  );

  always_comb begin
    merge_word = merge_lane(RD, addr_q[1:0], op_q, wdata_q);
    accept_bad = !(is_load(opcode) || is_store(opcode)) || is_misaligned(opcode, addr[1:0]);
  end

  // WE is a register with async reset, so asserting RST drops it at once and
  // a write in flight is never committed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'd0;
      A       <= '0;
      WD      <= 32'd0;
      WE      <= 1'b0;
      op_q    <= 6'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            op_q    <= opcode;
            addr_q  <= addr;
            wdata_q <= wdata;
            ready   <= 1'b0;
            A       <= {addr[ADDR_W-1:2], 2'b00};
            if (accept_bad) begin
              // Error path: straight to the response, memory untouched.
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (is_load(opcode)) begin
              state <= LOAD;
            end else if (opcode == OP_SW) begin
              // Full-word store needs no read; write data is the request data.
              state <= WRITE;
              WD    <= wdata;
              WE    <= 1'b1;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          rdata <= load_val;
          state <= RESP;
          done  <= 1'b1;
          err   <= 1'b0;
        end
        RMW_RD: begin
          WD    <= merge_word;
          WE    <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          // Memory commits on this edge; WD keeps the merge word afterwards.
          WE    <= 1'b0;
          state <= RESP;
          done  <= 1'b1;
          err   <= 1'b0;
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b1;
          err   <= 1'b0;
          A     <= '0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          err   <= 1'b0;
          WE    <= 1'b0;
          A     <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer for the MIPS MCU datapath; the initiator side of the word-addressed data memory port (A, WD, WE, RD). It accepts one load or store request at a time from the core. It drives the data memory with word-aligned addresses and returns extracted, sign- or zero-extended load data. Sub-word stores are implemented as read-modify-write on the 32-bit memory.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of core and memory address.

Ports:
- CLK  in  1  single clock; every register updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- req  in  1  request valid; sampled only when ready=1.
- opcode  in  6  MIPS opcode: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011.
- addr  in  ADDR_W  byte address from the ALU.
- wdata  in  32  store data; low byte/halfword is used for SB/SH.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse when a request completes.
- err  out  1  valid with done; 1 means misaligned access or illegal opcode.
- rdata  out  32  load result; holds its value until the next successful load.
- A  out  ADDR_W  memory address, always with [1:0]=00.
- WD  out  32  memory write data.
- WE  out  1  memory write enable.
- RD  in  32  memory read data; combinational in A (asynchronous read).

## Operation
- Byte lanes are little-endian: offset 0 is bits [7:0], offset 3 is bits [31:24].
- On accept (IDLE, req=1), latch the opcode, addr, and wdata.
- Misaligned cases: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- A misaligned request or any unlisted opcode goes to RESP with err=1. No memory access occurs and rdata is unchanged.
- States and transitions:
  - IDLE → LOAD for loads.
  - IDLE → WRITE for SW.
  - IDLE → RMW_RD for SB/SH.
  - IDLE → RESP on error.
  - LOAD → RESP. In LOAD, RD is captured and the selected lane is extracted. LB/LH sign-extend; LBU/LHU zero-extend. The result is written to rdata.
  - RMW_RD → WRITE. In RMW_RD, RD is captured and the SB/SH lane is replaced with wdata[7:0] or wdata[15:0] to form the merge word.
  - WRITE → RESP. In WRITE, WE=1 and WD is the merge word (SW: latched wdata).
  - RESP → IDLE. In RESP, done=1 and err is valid.
- A = {latched addr[ADDR_W-1:2], 2'b00} in every non-IDLE state; 0 in IDLE.
- WD is registered and holds its last value outside WRITE.
- WE is high only in WRITE.
- req while ready=0 is ignored (not queued).

## Timing
- Reset values: state IDLE, ready=1, done=0, err=0, rdata=0, A=0, WD=0, WE=0.
- Asserting RST mid-operation clears WE immediately (asynchronously), so no partial write occurs. The in-flight request is dropped with no done.
- Latency from the accept edge to the done cycle:
  - Load: 2 cycles (LOAD, RESP).
  - SW: 2 cycles (WRITE, RESP).
  - SB/SH: 3 cycles (RMW_RD, WRITE, RESP).
  - Error: 1 cycle (RESP).
- rdata is updated on the edge leaving LOAD and is stable while done=1.
- ready returns high the cycle after RESP. The next accept is possible on that cycle, giving back-to-back throughput of one request per 3–4 cycles.
- The memory commits the write on the edge ending WRITE. A load issued right after a store therefore reads the new data.

## Structure
- Shared package holds the opcode constants (OP_LB … OP_SW), the state encoding (IDLE, LOAD, RMW_RD, WRITE, RESP), and the byte-lane/extend helper function.
- One natural sub-module: `load_extract`, combinational. Inputs are RD, addr[1:0], and opcode; output is the 32-bit extended load value. It is reused by the core for debug readback.
- Remaining logic is the FSM plus merge and register logic in one module.

## Test plan
- Reset mid-op: pulse RST during WRITE → WE drops the same cycle, mem[0x04] is unchanged, ready=1, rdata=0.
- LW then LB/LBU: mem[0x10]=0x8899AABB.
  - LW 0x10 → rdata=0x8899AABB two cycles after accept.
  - LB 0x13 → 0xFFFFFF88.
  - LBU 0x13 → 0x00000088.
  - LH 0x10 → 0xFFFFAABB.
- SB read-modify-write: mem[0x20]=0x11223344, SB 0x21 with wdata=0xCD → exactly one WE pulse at A=0x20, WD=0x1122CD44, done 3 cycles after accept.
- Misaligned: LW 0x22 and SH 0x23 → done with err=1 one cycle after accept, WE never high, rdata unchanged.
- Back-to-back: SW 0x30 with 0xDEADBEEF, then LW 0x30 accepted the cycle ready returns → rdata=0xDEADBEEF. A req asserted while busy is ignored.
- Illegal opcode 0x00 with req → err=1, no memory activity.
